// File: rtl/gray_decoder_if.sv
// Handshake bundle for gray_decoder: Gray codeword input stream and decoded binary result stream.
// The slave modport is the decoder side, and the master modport is the source/consumer side.
interface gray_decoder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_up;
  logic             step_err;
  logic [7:0]       err_count;

  modport master (
    output in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, out_up, step_err, err_count
  );

  modport slave (
    input  in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, out_up, step_err, err_count
  );
endinterface

// File: rtl/gray_decoder.sv
// Streaming Gray-to-binary decoder with a single registered output slot.
// Define GRAY_STEP_CHECK_EN to add single-bit step checking, count direction and a saturating error count.
module gray_decoder #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  gray_decoder_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic [WIDTH-1:0] dec_bin;
  logic             accept;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    dec_bin = '0;
    dec_bin[WIDTH-1] = bus.in_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ bus.in_gray[i];
    end
  end

  assign bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_bin   = out_bin_q;

  always_comb begin
    state_d   = state_q;
    out_bin_d = out_bin_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (bus.out_ready && !accept) state_d = EMPTY;
    endcase
    if (accept) out_bin_d = dec_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      out_bin_q <= '0;
    end else begin
      state_q   <= state_d;
      out_bin_q <= out_bin_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0] diff;
  logic             first_q, first_d;
  logic             step_err_q, step_err_d;
  logic             out_up_q, out_up_d;
  logic             bad_step;
  logic [7:0]       err_count_q, err_count_d;

  // A legal step flips exactly one bit: diff is non-zero and a power of two.
  always_comb begin
    diff        = bus.in_gray ^ prev_gray_q;
    bad_step    = (diff == '0) || ((diff & (diff - WIDTH'(1))) != '0);
    prev_gray_d = prev_gray_q;
    prev_bin_d  = prev_bin_q;
    first_d     = first_q;
    step_err_d  = step_err_q;
    out_up_d    = out_up_q;
    err_count_d = err_count_q;
    if (accept) begin
      prev_gray_d = bus.in_gray;
      prev_bin_d  = dec_bin;
      first_d     = 1'b0;
      if (first_q) begin
        step_err_d = 1'b0;
        out_up_d   = 1'b0;
      end else begin
        step_err_d = bad_step;
        out_up_d   = !bad_step && (dec_bin == prev_bin_q + WIDTH'(1));
        if (bad_step && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_q <= '0;
      prev_bin_q  <= '0;
      first_q     <= 1'b1;
      step_err_q  <= 1'b0;
      out_up_q    <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      prev_gray_q <= prev_gray_d;
      prev_bin_q  <= prev_bin_d;
      first_q     <= first_d;
      step_err_q  <= step_err_d;
      out_up_q    <= out_up_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_up    = out_up_q;
  assign bus.step_err  = step_err_q;
  assign bus.err_count = err_count_q;
`else
  assign bus.out_up    = 1'b0;
  assign bus.step_err  = 1'b0;
  assign bus.err_count = 8'd0;
`endif

endmodule
